// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_code_counter
// Description : Up/down Gray-code counter with load, wrap pulse and update
//               strobe; gray_out and bin_out come from one binary count.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             upd
);

    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_upd;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic             w_wrap_next;
    logic             w_upd_next;

    // Each binary bit is the XOR of all Gray bits at or above it; written
    // per bit as a reduction to avoid a bit-to-bit combinational chain.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load_bin[i] = ^(load_gray >> i);
        end
    end

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        w_upd_next  = 1'b0;
        if (load) begin
            w_bin_next = w_load_bin;
            w_upd_next = 1'b1;
        end else if (en) begin
            w_upd_next = 1'b1;
            if (up_dn) begin
                w_bin_next  = r_bin + c_one;
                w_wrap_next = (r_bin == c_all_ones);
            end else begin
                w_bin_next  = r_bin - c_one;
                w_wrap_next = (r_bin == c_zero);
            end
        end
    end

    // Both buses load from the same next value so they are never skewed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_bin_next ^ (w_bin_next >> 1);
            r_wrap <= w_wrap_next;
            r_upd  <= w_upd_next;
        end
    end

    assign gray_out = r_gray;
    assign bin_out  = r_bin;
    assign wrap     = r_wrap;
    assign upd      = r_upd;

endmodule
`default_nettype wire

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
Synchronous N-bit Gray-code sequence generator. It sits directly upstream of the Gray-to-binary code converter and drives that converter's Gray input. It keeps an internal binary count and registers the Gray encoding, so the output changes exactly one bit per step. It also exports the matching binary value, a wrap pulse and an update strobe, so the bench can check the downstream converter against a golden value.

Parameters:
WIDTH, 4, counter and Gray bus width in bits; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance one Gray step per clock while high
up_dn  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous load of load_gray; has priority over en
load_gray  input  WIDTH  Gray-coded value to load
gray_out  output  WIDTH  registered Gray code, feeds the downstream converter
bin_out  output  WIDTH  registered binary equivalent of gray_out
wrap  output  1  one-cycle pulse when the step crossed the sequence end
upd  output  1  one-cycle strobe: gray_out changed on this edge

Behaviour:
- Reset (rst_n low, asynchronous, clock not required):
  - internal binary count = 0, gray_out = 0, bin_out = 0, wrap = 0, upd = 0.
  - Reset release is synchronous in effect: the first update occurs on the first rising clk edge with rst_n high and load or en high.
- Internal state is the binary count B[WIDTH-1:0]. gray_out = B ^ (B >> 1) and bin_out = B, both registered from the same next-state value. They are never skewed.
- Priority on each rising edge: load, then en, then hold.
  - load = 1:
    - B <= Gray-to-binary(load_gray), computed as b[MSB] = g[MSB] and b[i] = b[i+1] ^ g[i].
    - upd <= 1 and wrap <= 0, whatever the values of en and up_dn.
  - load = 0, en = 1, up_dn = 1:
    - B <= B + 1, modulo 2^WIDTH.
    - wrap <= 1 only when B was 2^WIDTH-1 (next B = 0).
    - upd <= 1.
  - load = 0, en = 1, up_dn = 0:
    - B <= B - 1, modulo 2^WIDTH.
    - wrap <= 1 only when B was 0 (next B = 2^WIDTH-1).
    - upd <= 1.
  - load = 0, en = 0: B, gray_out and bin_out hold; wrap <= 0; upd <= 0.
- Latency: one clock from a qualifying edge to the new gray_out, bin_out, wrap and upd. wrap and upd are high for exactly one cycle per step and are not sticky.
- Gray property: on every en step, including wrap-around, gray_out differs from its previous value in exactly one bit. A load may change any number of bits.
- Changing up_dn mid-run takes effect on the next en edge with no dead cycle. For example, up then down from 5 returns to 5.
- Holding en high continuously steps every cycle. Upd then stays high every cycle, which is legal.
- Reset asserted mid-sequence clears all outputs immediately, asynchronously. No step is pending after release.
- Inputs are sampled on rising clk only. Glitches between edges have no effect.

Test Plan:
1. Reset, then en = 1, up_dn = 1 for 16 cycles (WIDTH = 4) -> gray_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0. wrap is high only on the 8 -> 0 edge. upd is high every cycle. bin_out steps 0..15. Every step flips exactly one bit.
2. From reset, en = 1, up_dn = 0 for 2 cycles -> B = 15 then 14, gray_out = 8 then 9. wrap pulses on the first edge only.
3. load = 1, load_gray = 4'hC, en = 1 in the same cycle -> gray_out = C, bin_out = 8, upd = 1, wrap = 0. The en step is ignored that cycle. The next en up-step gives gray_out = D, bin_out = 9.
4. Count up to bin_out = 5, then up_dn = 0 with en = 1 for 2 cycles -> bin_out = 4, 3 and gray_out = 6, 2. Then en = 0 for 3 cycles -> outputs hold, upd = 0, wrap = 0.
5. Mid-run at gray_out = 7, drive rst_n low between clock edges -> all outputs read 0 before the next edge. Release rst_n with en = 1 -> the next edge gives gray_out = 1.
6. Chain into the downstream converter with a free-running en = 1, up_dn = 1 -> the converter's binary output equals bin_out every cycle across at least two full wraps.
